mem_access_seq: RTL and testbench

Multicycle sequencer that executes one load/store on behalf of the main control unit against the byte-addressed, 32-bit-wide data memory. It handles word, halfword and byte accesses. Loads are extracted and sign-extended; sub-word stores are done as read-modify-write. Misaligned addresses and illegal opcodes are reported without touching memory. It sits between the control FSM (start/done handshake) and the memory port, replacing hand-coded wait states in the main controller.

---
 rtl/mem_access_seq.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// mem_access_seq: multicycle load/store sequencer between the control FSM
// and a byte-addressed, word-wide data memory with fixed read latency.
// Sub-word loads are sign-extended; sub-word stores use read-modify-write.
module mem_access_seq #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  typedef enum logic [2:0] {
    OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB, OP_IL6, OP_IL7
  } op_t;

  // READ lasts MEM_LATENCY+1 cycles: counter runs MEM_LATENCY down to 0
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  op_t         op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;

  logic        busy_d, done_d, err_d, mem_wr_d;
  logic [31:0] rdata_d, mem_addr_d, mem_wdata_d;

  logic        bad_req;
  logic [15:0] sel_half;
  logic [7:0]  sel_byte;
  logic [31:0] merged;

  // Request legality and lane selection/merge helpers
  always_comb begin
    bad_req = 1'b0;
    case (op_t'(op))
      OP_LW, OP_SW: bad_req = (addr[1:0] != 2'b00);
      OP_LH, OP_SH: bad_req = addr[0];
      OP_LB, OP_SB: bad_req = 1'b0;
      default:      bad_req = 1'b1;
    endcase

    sel_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lane_q)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase

    merged = mem_rdata;
    if (op_q == OP_SH) begin
      if (lane_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    busy_d      = busy;
    done_d      = 1'b0;
    err_d       = err;
    mem_wr_d    = 1'b0;
    rdata_d     = rdata;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          op_d    = op_t'(op);
          lane_d  = addr[1:0];
          wdata_d = wdata;
          busy_d  = 1'b1;
          if (bad_req) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            err_d      = 1'b0;
            mem_addr_d = {addr[31:2], 2'b00};
            if (op_t'(op) == OP_SW) begin
              mem_wdata_d = wdata;
              mem_wr_d    = 1'b1;
              state_d     = WRITE;
            end else begin
              cnt_d   = CNT_INIT;
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (cnt_q == 4'd0) begin
          case (op_q)
            OP_LW: begin
              rdata_d = mem_rdata;
              done_d  = 1'b1;
              state_d = DONE;
            end
            OP_LH: begin
              rdata_d = {{16{sel_half[15]}}, sel_half};
              done_d  = 1'b1;
              state_d = DONE;
            end
            OP_LB: begin
              rdata_d = {{24{sel_byte[7]}}, sel_byte};
              done_d  = 1'b1;
              state_d = DONE;
            end
            default: begin
              mem_wdata_d = merged;
              mem_wr_d    = 1'b1;
              state_d     = WRITE;
            end
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITE: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_LW;
      lane_q    <= '0;
      wdata_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_wr    <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      lane_q    <= lane_d;
      wdata_q   <= wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      mem_wr    <= mem_wr_d;
      rdata     <= rdata_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Testbench for mem_access_seq: two instances (latency 1 and 4), each with
// its own latency-modelled memory, checked against an arithmetic model.
module tb_mem_access_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic [1:0]  start_v, busy_v, done_v, err_v, mem_wr_v;
  logic [31:0] rdata_v [2];
  logic [31:0] mem_addr_v [2];
  logic [31:0] mem_wdata_v [2];
  logic [31:0] mem_rdata_v [2];

  mem_access_seq #(.MEM_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .start(start_v[0]), .op(op), .addr(addr),
    .wdata(wdata), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
    .rdata(rdata_v[0]), .mem_addr(mem_addr_v[0]), .mem_wr(mem_wr_v[0]),
    .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata_v[0]));

  mem_access_seq #(.MEM_LATENCY(4)) dut4 (
    .clock(clock), .reset(reset), .start(start_v[1]), .op(op), .addr(addr),
    .wdata(wdata), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
    .rdata(rdata_v[1]), .mem_addr(mem_addr_v[1]), .mem_wr(mem_wr_v[1]),
    .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata_v[1]));

  // Physical memories (written only by the DUTs) and expected contents
  logic [31:0] mem     [2][64];
  logic [31:0] ref_mem [2][64];
  logic        mem_load;
  int          held [2] = '{0, 0};
  logic [31:0] last_a [2] = '{32'h0, 32'h0};

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'h8899AABB;
    return 32'h13570000 + 32'(i) * 32'h01010101;
  endfunction

  // Memory write port; a load request fills both memories with the pattern
  always @(posedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (mem_load) begin
        for (int i = 0; i < 64; i++) mem[s][i] <= init_word(i);
      end else if (mem_wr_v[s]) begin
        mem[s][mem_addr_v[s][7:2]] <= mem_wdata_v[s];
      end
    end
  end

  // Count how many cycles the current address has been held
  always @(negedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (mem_addr_v[s] == last_a[s]) held[s] <= held[s] + 1;
      else held[s] <= 1;
      last_a[s] <= mem_addr_v[s];
    end
  end

  // Read data is garbage until the address has been held latency+1 cycles
  assign mem_rdata_v[0] = (held[0] >= 2) ? mem[0][mem_addr_v[0][7:2]] : 32'h5A5AA5A5;
  assign mem_rdata_v[1] = (held[1] >= 5) ? mem[1][mem_addr_v[1][7:2]] : 32'h5A5AA5A5;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_rdata [2];
  logic [31:0] exp_maddr [2];

  function automatic logic [31:0] model_load(logic [2:0] o, logic [31:0] w, logic [1:0] ln);
    int unsigned v;
    int unsigned sh;
    if (o == 3'd0) return w;
    if (o == 3'd1) begin
      sh = 16 * int'(ln) / 2 / 1;
      sh = (int'(ln) >= 2) ? 16 : 0;
      v  = (w >> sh) & 32'hFFFF;
      if (v >= 32768) v = v + 32'hFFFF0000;
      return v;
    end
    sh = 8 * int'(ln);
    v  = (w >> sh) & 32'hFF;
    if (v >= 128) v = v + 32'hFFFFFF00;
    return v;
  endfunction

  function automatic logic [31:0] model_merge(logic [2:0] o, logic [31:0] w,
                                              logic [31:0] wd, logic [1:0] ln);
    int unsigned sh;
    int unsigned mask;
    if (o == 3'd4) begin
      sh   = (int'(ln) >= 2) ? 16 : 0;
      mask = 32'hFFFF << sh;
    end else begin
      sh   = 8 * int'(ln);
      mask = 32'hFF << sh;
    end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic run_op(input int s, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input bit stray);
    int lat = (s == 0) ? 1 : 4;
    int idx = int'(a[7:2]);
    logic [31:0] word = ref_mem[s][idx];
    bit e_err;
    int e_done, e_wr;
    logic [31:0] e_wdata;
    int got_done = 0;
    int wr_cnt = 0;
    int wr_at = 0;

    e_err = (o > 3'd5) || ((o == 3'd0 || o == 3'd3) && a[1:0] != 2'b00) ||
            ((o == 3'd1 || o == 3'd4) && a[0]);
    if (e_err)           begin e_done = 1;       e_wr = 0;       end
    else if (o == 3'd3)  begin e_done = 2;       e_wr = 1;       end
    else if (o < 3'd3)   begin e_done = lat + 2; e_wr = 0;       end
    else                 begin e_done = lat + 3; e_wr = lat + 2; end
    e_wdata = (o == 3'd3) ? wd : model_merge(o, word, wd, a[1:0]);
    if (!e_err) begin
      exp_maddr[s] = {a[31:2], 2'b00};
      if (o < 3'd3) exp_rdata[s] = model_load(o, word, a[1:0]);
    end

    @(negedge clock);
    op = o; addr = a; wdata = wd; start_v[s] = 1'b1;
    @(posedge clock);
    #1;
    start_v[s] = 1'b0;
    op = 3'($urandom); addr = $urandom; wdata = $urandom;

    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      start_v[s] = stray && (n == 1 || n == e_done);
      check("busy", 32'(busy_v[s]), 32'(n <= e_done));
      if (mem_wr_v[s]) begin
        wr_cnt++;
        wr_at = n;
        check("wr_data", mem_wdata_v[s], e_wdata);
        check("wr_addr", mem_addr_v[s], {a[31:2], 2'b00});
      end
      if (done_v[s]) begin
        got_done = n;
        break;
      end
    end

    check("done_cycle", got_done, e_done);
    if (got_done != 0) begin
      check("err", 32'(err_v[s]), 32'(e_err));
      check("rdata", rdata_v[s], exp_rdata[s]);
      check("mem_addr", mem_addr_v[s], exp_maddr[s]);
    end
    check("wr_count", wr_cnt, (e_wr != 0) ? 1 : 0);
    if (e_wr != 0) begin
      check("wr_cycle", wr_at, e_wr);
      ref_mem[s][idx] = e_wdata;
    end

    @(negedge clock);
    start_v[s] = 1'b0;
    check("busy_after", 32'(busy_v[s]), 32'h0);
    check("done_after", 32'(done_v[s]), 32'h0);
    check("wr_after", 32'(mem_wr_v[s]), 32'h0);
    check("mem_word", mem[s][idx], ref_mem[s][idx]);
  endtask

  // SB on the latency-1 instance, with reset sampled at the end of cycle 2
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] wd);
    int idx = int'(a[7:2]);
    @(negedge clock);
    op = 3'd5; addr = a; wdata = wd; start_v[0] = 1'b1;
    @(posedge clock);
    #1;
    start_v[0] = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      @(negedge clock);
      check("rst_busy_pre", 32'(busy_v[0]), 32'h1);
      check("rst_wr_pre", 32'(mem_wr_v[0]), 32'h0);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_busy", 32'(busy_v[0]), 32'h0);
    check("rst_done", 32'(done_v[0]), 32'h0);
    check("rst_err", 32'(err_v[0]), 32'h0);
    check("rst_wr", 32'(mem_wr_v[0]), 32'h0);
    check("rst_rdata", rdata_v[0], 32'h0);
    check("rst_maddr", mem_addr_v[0], 32'h0);
    check("rst_wdata", mem_wdata_v[0], 32'h0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      check("rst_wr_post", 32'(mem_wr_v[0]), 32'h0);
      check("rst_busy_post", 32'(busy_v[0]), 32'h0);
    end
    check("rst_mem", mem[0][idx], ref_mem[0][idx]);
    exp_rdata = '{32'h0, 32'h0};
    exp_maddr = '{32'h0, 32'h0};
  endtask

  initial begin
    reset = 1'b1; mem_load = 1'b1; start_v = '0;
    op = '0; addr = '0; wdata = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) ref_mem[s][i] = init_word(i);
    exp_rdata = '{32'h0, 32'h0};
    exp_maddr = '{32'h0, 32'h0};
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0; mem_load = 1'b0;

    for (int s = 0; s < 2; s++) begin
      check("reset_busy", 32'(busy_v[s]), 32'h0);
      check("reset_done", 32'(done_v[s]), 32'h0);
      check("reset_err", 32'(err_v[s]), 32'h0);
      check("reset_wr", 32'(mem_wr_v[s]), 32'h0);
      check("reset_rdata", rdata_v[s], 32'h0);
      check("reset_maddr", mem_addr_v[s], 32'h0);
      check("reset_wdata", mem_wdata_v[s], 32'h0);
    end

    run_op(0, 3'd2, 32'h13, 32'h0, 1'b0);
    check("lb13_value", rdata_v[0], 32'hFFFFFF88);
    run_op(0, 3'd2, 32'h10, 32'h0, 1'b1);
    run_op(0, 3'd1, 32'h12, 32'h0, 1'b0);
    run_op(0, 3'd0, 32'h10, 32'h0, 1'b0);
    run_op(0, 3'd1, 32'h10, 32'h0, 1'b1);
    run_op(0, 3'd5, 32'h11, 32'h123456CC, 1'b0);
    run_op(0, 3'd3, 32'h10, 32'h8899AABB, 1'b0);
    run_op(0, 3'd4, 32'h12, 32'h00001234, 1'b1);
    check("sh12_value", mem[0][4], 32'h1234AABB);
    run_op(0, 3'd3, 32'h10, 32'hDEADBEEF, 1'b0);
    run_op(0, 3'd0, 32'h12, 32'h0, 1'b0);
    run_op(0, 3'd4, 32'h11, 32'hFFFF, 1'b1);
    run_op(0, 3'd7, 32'h10, 32'h0, 1'b0);
    run_op(1, 3'd0, 32'h10, 32'h0, 1'b1);
    run_op(1, 3'd5, 32'h13, 32'hA5, 1'b0);

    reset_mid(32'h11, 32'h123456CC);

    for (int k = 0; k < 160; k++) begin
      int s = int'($urandom_range(0, 1));
      logic [2:0] o = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (o == 3'd0 || o == 3'd3) a[1:0] = 2'b00;
        if (o == 3'd1 || o == 3'd4) a[0] = 1'b0;
      end
      run_op(s, o, a, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
